pc_ctrl: RTL

Next-PC sequencing controller for the rv32i program counter. It accepts one decoded control-flow descriptor per handshake and resolves branch conditions from ALU flags. It drives the PC's 3-bit op code for exactly one cycle per accepted instruction, then blocks the front end for a fixed flush window after every taken redirect. It sits between decode/ALU and the PC; dec_imm and alu_res route to the PC directly and do not pass through this block.

---
 rtl/pc_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// Next-PC sequencing controller: accepts control-flow descriptors, resolves branches,
// issues one-cycle PC ops and holds the front end for a flush window after redirects.
// Optional performance counters are enabled with `define PC_CTRL_PERF_EN.
module pc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned XLEN         = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [2:0]       dec_kind,
  input  logic [2:0]       dec_funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             fetch_ready,
  input  logic             stall,
  output logic [2:0]       pc_op,
  output logic             flush,
  output logic             illegal,
  output logic             halted
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0]  retired_cnt,
  output logic [XLEN-1:0]  redirect_cnt
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_t;
  typedef enum logic [2:0] {OP_HOLD = 3'd0, OP_INC = 3'd1, OP_BRANCH = 3'd2,
                            OP_JAL = 3'd3, OP_JALR = 3'd4} pc_op_t;
  typedef enum logic [2:0] {K_SEQ = 3'd0, K_BRANCH = 3'd1, K_JAL = 3'd2,
                            K_JALR = 3'd3, K_HALT = 3'd4} kind_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || XLEN < 1) begin : g_param_check
    $error("pc_ctrl: FLUSH_CYCLES must be 1..7 and XLEN >= 1");
  end

  state_t     state;
  logic [2:0] flush_cnt;
  logic       accept;
  logic       br_taken;
  logic       br_bad;
  logic       redirect;
  logic       halt_req;
  pc_op_t     nxt_op;

  assign dec_ready = (state == S_RUN) & fetch_ready & ~stall;
  assign accept    = dec_valid & dec_ready;

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (dec_funct3)
      3'b000: br_taken = alu_zero;
      3'b001: br_taken = ~alu_zero;
      3'b100: br_taken = alu_lt;
      3'b101: br_taken = ~alu_lt;
      3'b110: br_taken = alu_ltu;
      3'b111: br_taken = ~alu_ltu;
      3'b010,
      3'b011: br_bad   = 1'b1;
    endcase
  end

  // Kinds 5-7 fall through to the default and behave as SEQ.
  always_comb begin
    nxt_op   = OP_INC;
    redirect = 1'b0;
    halt_req = 1'b0;
    case (dec_kind)
      K_BRANCH: begin
        if (br_taken) begin
          nxt_op   = OP_BRANCH;
          redirect = 1'b1;
        end
      end
      K_JAL: begin
        nxt_op   = OP_JAL;
        redirect = 1'b1;
      end
      K_JALR: begin
        nxt_op   = OP_JALR;
        redirect = 1'b1;
      end
      K_HALT: begin
        nxt_op   = OP_HOLD;
        halt_req = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_BOOT;
      flush_cnt <= '0;
      pc_op     <= OP_HOLD;
      flush     <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      pc_op   <= OP_HOLD;
      flush   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (accept) begin
            pc_op   <= nxt_op;
            flush   <= redirect;
            illegal <= (dec_kind == K_BRANCH) & br_bad;
            if (redirect) begin
              state     <= S_FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else if (halt_req) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end
        end
        // The window only counts cycles in which the pipeline is not stalled.
        S_FLUSH: begin
          if (!stall) begin
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt == 3'd1) state <= S_RUN;
          end
        end
        S_HALT: halted <= 1'b1;
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef PC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_cnt  <= '0;
      redirect_cnt <= '0;
    end else if (accept) begin
      if (retired_cnt != '1) retired_cnt <= retired_cnt + XLEN'(1);
      if (redirect && redirect_cnt != '1) redirect_cnt <= redirect_cnt + XLEN'(1);
    end
  end
`endif

endmodule
